// File: rtl/tec_ctrl_pkg.sv
// Shared mode codes, state/beat encodings and mode helpers for the TEC sequencer.
package tec_ctrl_pkg;

  localparam logic [2:0] MODE_RUN  = 3'b000;
  localparam logic [2:0] MODE_MEMW = 3'b001;
  localparam logic [2:0] MODE_MEMR = 3'b010;
  localparam logic [2:0] MODE_REGR = 3'b011;
  localparam logic [2:0] MODE_REGW = 3'b100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    PAUSE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    B1 = 2'd0,
    B2 = 2'd1,
    B3 = 2'd2
  } beat_t;

  function automatic logic mode_legal(input logic [2:0] m);
    return (m <= MODE_REGW);
  endfunction

  function automatic logic mode_is_reg(input logic [2:0] m);
    return (m == MODE_REGR) || (m == MODE_REGW);
  endfunction

endpackage

// File: rtl/tec_beat_gen.sv
// One-hot W1/W2/W3 beat generator; flags the beat that closes the machine cycle.
module tec_beat_gen
  import tec_ctrl_pkg::*;
(
  input  logic clk,
  input  logic clr_n,
  input  logic enable,
  input  logic short_cyc,
  input  logic long_cyc,
  input  logic restart,
  output logic w1,
  output logic w2,
  output logic w3,
  output logic cycle_end
);

  beat_t beat;
  logic  live;

  assign live = w1 | w2 | w3;

  // SHORT/LONG are sampled at the edge that ends the current beat
  always_comb begin
    cycle_end = 1'b0;
    if (enable && live) begin
      case (beat)
        B1:      cycle_end = short_cyc;
        B2:      cycle_end = !long_cyc;
        default: cycle_end = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      beat <= B1;
      w1   <= 1'b0;
      w2   <= 1'b0;
      w3   <= 1'b0;
    end else if (restart) begin
      beat <= B1;
      w1   <= 1'b1;
      w2   <= 1'b0;
      w3   <= 1'b0;
    end else if (!enable || cycle_end || !live) begin
      beat <= B1;
      w1   <= 1'b0;
      w2   <= 1'b0;
      w3   <= 1'b0;
    end else begin
      case (beat)
        B1: begin
          beat <= B2;
          w1   <= 1'b0;
          w2   <= 1'b1;
        end
        B2: begin
          beat <= B3;
          w2   <= 1'b0;
          w3   <= 1'b1;
        end
        default: begin
          beat <= B1;
          w1   <= 1'b0;
          w2   <= 1'b0;
          w3   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/tec_ctrl_seq.sv
// TEC controller sequencer: console mode latch, STO setup flag, register sweep and
// run/pause/step control around the internal beat generator.
module tec_ctrl_seq
  import tec_ctrl_pkg::*;
#(
  parameter int NREG = 4,
  parameter int IRW  = 4
) (
  input  logic                     T3,
  input  logic                     CLR,
  input  logic                     START,
  input  logic                     RSWC,
  input  logic                     RSWB,
  input  logic                     RSWA,
  input  logic                     STEP_EN,
  input  logic                     SHORT,
  input  logic                     LONG,
  input  logic                     HALT,
  input  logic [IRW-1:0]           IR_IN,
  output logic [IRW-1:0]           IR_OUT,
  output logic                     W1,
  output logic                     W2,
  output logic                     W3,
  output logic [2:0]               MODE,
  output logic                     STO,
  output logic [$clog2(NREG)-1:0]  REGSEL,
  output logic                     STOP,
  output logic                     ERR
);

  localparam int            RW       = $clog2(NREG);
  localparam logic [RW-1:0] REG_LAST = RW'(NREG - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] sw;
  logic       sw_ok;
  logic       halt_hit;
  logic       beat_en;
  logic       restart;
  logic       cycle_end;
  logic       last_reg;

  assign sw       = {RSWC, RSWB, RSWA};
  assign sw_ok    = mode_legal(sw);
  assign halt_hit = (state == ACTIVE) && (MODE == MODE_RUN) && HALT;
  assign beat_en  = (state == ACTIVE) && !halt_hit;
  assign last_reg = (REGSEL == REG_LAST);

  // HALT in RUN pre-empts every beat rule, so it is resolved before cycle_end
  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    case (state)
      IDLE: begin
        if (START && sw_ok) begin
          state_nxt = ACTIVE;
          restart   = 1'b1;
        end
      end
      PAUSE: begin
        if (START) begin
          state_nxt = ACTIVE;
          restart   = 1'b1;
        end
      end
      ACTIVE: begin
        if (halt_hit) begin
          state_nxt = IDLE;
        end else if (cycle_end) begin
          if (!STO) begin
            restart = 1'b1;
          end else begin
            case (MODE)
              MODE_REGR, MODE_REGW: begin
                if (last_reg) state_nxt = IDLE;
                else          restart   = 1'b1;
              end
              MODE_MEMW, MODE_MEMR: state_nxt = PAUSE;
              default: begin
                if (STEP_EN) state_nxt = PAUSE;
                else         restart   = 1'b1;
              end
            endcase
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  tec_beat_gen u_beat (
    .clk       (T3),
    .clr_n     (CLR),
    .enable    (beat_en),
    .short_cyc (SHORT),
    .long_cyc  (LONG),
    .restart   (restart),
    .w1        (W1),
    .w2        (W2),
    .w3        (W3),
    .cycle_end (cycle_end)
  );

  always_ff @(posedge T3) begin
    if (!CLR) begin
      state  <= IDLE;
      MODE   <= MODE_RUN;
      STO    <= 1'b0;
      REGSEL <= '0;
      STOP   <= 1'b1;
      ERR    <= 1'b0;
      IR_OUT <= '0;
    end else begin
      state <= state_nxt;
      STOP  <= (state_nxt != ACTIVE);
      ERR   <= (state == IDLE) && START && !sw_ok;
      if (restart) IR_OUT <= IR_IN;
      // REGSEL returns to 0 when the sweep retires to IDLE, never rolling over mid-sweep
      if ((state == IDLE) && START) begin
        MODE   <= sw;
        STO    <= 1'b0;
        REGSEL <= '0;
      end else if (beat_en && cycle_end) begin
        if (!STO) begin
          STO    <= 1'b1;
          REGSEL <= '0;
        end else if (mode_is_reg(MODE)) begin
          REGSEL <= last_reg ? '0 : REGSEL + RW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tec_ctrl_seq.sv
// Directed-vector bench for tec_ctrl_seq: stimulus queues expected outputs per edge,
// a separate monitor pops and compares them one step after each T3 edge.
module tb_tec_ctrl_seq;

  localparam int NREG = 4;
  localparam int IRW  = 4;

  logic           T3 = 1'b0;
  logic           clr_s, start_s, step_s, short_s, long_s, halt_s;
  logic [2:0]     sw_s;
  logic [IRW-1:0] ir_s;
  logic [IRW-1:0] ir_out;
  logic           w1, w2, w3, sto, stop, err;
  logic [2:0]     mode;
  logic [1:0]     regsel;

  typedef struct packed {
    logic [2:0] w;
    logic [2:0] mode;
    logic       sto;
    logic [1:0] regsel;
    logic       stop;
    logic       err;
    logic [3:0] ir;
  } obs_t;

  obs_t exp_q[$];
  int   id_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   step_no = 0;

  always #5 T3 = ~T3;

  tec_ctrl_seq #(.NREG(NREG), .IRW(IRW)) dut (
    .T3      (T3),
    .CLR     (clr_s),
    .START   (start_s),
    .RSWC    (sw_s[2]),
    .RSWB    (sw_s[1]),
    .RSWA    (sw_s[0]),
    .STEP_EN (step_s),
    .SHORT   (short_s),
    .LONG    (long_s),
    .HALT    (halt_s),
    .IR_IN   (ir_s),
    .IR_OUT  (ir_out),
    .W1      (w1),
    .W2      (w2),
    .W3      (w3),
    .MODE    (mode),
    .STO     (sto),
    .REGSEL  (regsel),
    .STOP    (stop),
    .ERR     (err)
  );

  // Queue the outputs required after the coming edge, then move to the next negedge.
  task automatic chk(input logic [2:0] w, input logic [2:0] m, input logic s,
                     input logic [1:0] r, input logic st, input logic e, input logic [3:0] ir);
    obs_t o;
    o.w = w; o.mode = m; o.sto = s; o.regsel = r; o.stop = st; o.err = e; o.ir = ir;
    exp_q.push_back(o);
    id_q.push_back(step_no);
    step_no++;
    @(negedge T3);
  endtask

  initial begin
    obs_t e;
    obs_t a;
    int   id;
    forever begin
      @(posedge T3);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        id = id_q.pop_front();
        a.w = {w3, w2, w1}; a.mode = mode; a.sto = sto; a.regsel = regsel;
        a.stop = stop; a.err = err; a.ir = ir_out;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL step%0d: got w=%b mode=%b sto=%b regsel=%0d stop=%b err=%b ir=%h, expected w=%b mode=%b sto=%b regsel=%0d stop=%b err=%b ir=%h",
                   id, a.w, a.mode, a.sto, a.regsel, a.stop, a.err, a.ir,
                   e.w, e.mode, e.sto, e.regsel, e.stop, e.err, e.ir);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "bench timeout");
  end

  initial begin
    clr_s = 1'b0; start_s = 1'b0; step_s = 1'b0; short_s = 1'b0;
    long_s = 1'b0; halt_s = 1'b0; sw_s = 3'b000; ir_s = 4'h0;
    @(negedge T3);

    // Reset held for three edges, then released
    chk(3'b000, 3'b000, 0, 0, 1, 0, 4'h0);
    chk(3'b000, 3'b000, 0, 0, 1, 0, 4'h0);
    chk(3'b000, 3'b000, 0, 0, 1, 0, 4'h0);
    clr_s = 1'b1;
    chk(3'b000, 3'b000, 0, 0, 1, 0, 4'h0);

    // REGW sweep: setup + 4 register cycles of W1,W2
    start_s = 1'b1; sw_s = 3'b100; ir_s = 4'hA;
    chk(3'b001, 3'b100, 0, 0, 0, 0, 4'hA);
    start_s = 1'b0;
    chk(3'b010, 3'b100, 0, 0, 0, 0, 4'hA);
    chk(3'b001, 3'b100, 1, 0, 0, 0, 4'hA);
    ir_s = 4'h5;
    chk(3'b010, 3'b100, 1, 0, 0, 0, 4'hA);
    chk(3'b001, 3'b100, 1, 1, 0, 0, 4'h5);
    chk(3'b010, 3'b100, 1, 1, 0, 0, 4'h5);
    chk(3'b001, 3'b100, 1, 2, 0, 0, 4'h5);
    chk(3'b010, 3'b100, 1, 2, 0, 0, 4'h5);
    chk(3'b001, 3'b100, 1, 3, 0, 0, 4'h5);
    chk(3'b010, 3'b100, 1, 3, 0, 0, 4'h5);
    chk(3'b000, 3'b100, 1, 0, 1, 0, 4'h5);
    chk(3'b000, 3'b100, 1, 0, 1, 0, 4'h5);

    // RUN with LONG: W1,W2,W3,W1 then HALT+SHORT at W1 -> IDLE
    start_s = 1'b1; sw_s = 3'b000; ir_s = 4'h2; long_s = 1'b1;
    chk(3'b001, 3'b000, 0, 0, 0, 0, 4'h2);
    start_s = 1'b0;
    chk(3'b010, 3'b000, 0, 0, 0, 0, 4'h2);
    chk(3'b100, 3'b000, 0, 0, 0, 0, 4'h2);
    chk(3'b001, 3'b000, 1, 0, 0, 0, 4'h2);
    halt_s = 1'b1; short_s = 1'b1;
    chk(3'b000, 3'b000, 1, 0, 1, 0, 4'h2);
    halt_s = 1'b0; long_s = 1'b0;
    chk(3'b000, 3'b000, 1, 0, 1, 0, 4'h2);

    // RUN with SHORT: free-running, then single-step pause, resume, HALT
    start_s = 1'b1;
    chk(3'b001, 3'b000, 0, 0, 0, 0, 4'h2);
    start_s = 1'b0;
    chk(3'b001, 3'b000, 1, 0, 0, 0, 4'h2);
    chk(3'b001, 3'b000, 1, 0, 0, 0, 4'h2);
    step_s = 1'b1;
    chk(3'b000, 3'b000, 1, 0, 1, 0, 4'h2);
    chk(3'b000, 3'b000, 1, 0, 1, 0, 4'h2);
    start_s = 1'b1;
    chk(3'b001, 3'b000, 1, 0, 0, 0, 4'h2);
    start_s = 1'b0; halt_s = 1'b1;
    chk(3'b000, 3'b000, 1, 0, 1, 0, 4'h2);
    halt_s = 1'b0; step_s = 1'b0; short_s = 1'b0;

    // Illegal mode: one-cycle ERR, no beats
    start_s = 1'b1; sw_s = 3'b111;
    chk(3'b000, 3'b111, 0, 0, 1, 1, 4'h2);
    start_s = 1'b0;
    chk(3'b000, 3'b111, 0, 0, 1, 0, 4'h2);
    chk(3'b000, 3'b111, 0, 0, 1, 0, 4'h2);

    // REGR sweep interrupted by CLR during W2
    start_s = 1'b1; sw_s = 3'b011; ir_s = 4'h6;
    chk(3'b001, 3'b011, 0, 0, 0, 0, 4'h6);
    start_s = 1'b0;
    chk(3'b010, 3'b011, 0, 0, 0, 0, 4'h6);
    chk(3'b001, 3'b011, 1, 0, 0, 0, 4'h6);
    chk(3'b010, 3'b011, 1, 0, 0, 0, 4'h6);
    chk(3'b001, 3'b011, 1, 1, 0, 0, 4'h6);
    chk(3'b010, 3'b011, 1, 1, 0, 0, 4'h6);
    clr_s = 1'b0;
    chk(3'b000, 3'b000, 0, 0, 1, 0, 4'h0);
    clr_s = 1'b1;
    chk(3'b000, 3'b000, 0, 0, 1, 0, 4'h0);

    // Fresh REGR sweep from REGSEL=0
    start_s = 1'b1;
    chk(3'b001, 3'b011, 0, 0, 0, 0, 4'h6);
    start_s = 1'b0;
    chk(3'b010, 3'b011, 0, 0, 0, 0, 4'h6);
    chk(3'b001, 3'b011, 1, 0, 0, 0, 4'h6);
    chk(3'b010, 3'b011, 1, 0, 0, 0, 4'h6);
    for (int r = 1; r < NREG; r++) begin
      chk(3'b001, 3'b011, 1, 2'(r), 0, 0, 4'h6);
      chk(3'b010, 3'b011, 1, 2'(r), 0, 0, 4'h6);
    end
    chk(3'b000, 3'b011, 1, 0, 1, 0, 4'h6);

    // MEMR: setup, one access, PAUSE; resume keeps MODE/STO, START while active ignored
    start_s = 1'b1; sw_s = 3'b010; ir_s = 4'h3;
    chk(3'b001, 3'b010, 0, 0, 0, 0, 4'h3);
    start_s = 1'b0;
    chk(3'b010, 3'b010, 0, 0, 0, 0, 4'h3);
    chk(3'b001, 3'b010, 1, 0, 0, 0, 4'h3);
    chk(3'b010, 3'b010, 1, 0, 0, 0, 4'h3);
    chk(3'b000, 3'b010, 1, 0, 1, 0, 4'h3);
    chk(3'b000, 3'b010, 1, 0, 1, 0, 4'h3);
    start_s = 1'b1; sw_s = 3'b111; ir_s = 4'h7;
    chk(3'b001, 3'b010, 1, 0, 0, 0, 4'h7);
    chk(3'b010, 3'b010, 1, 0, 0, 0, 4'h7);
    start_s = 1'b0;
    chk(3'b000, 3'b010, 1, 0, 1, 0, 4'h7);

    @(posedge T3);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
